// File: rtl/bit_sampler_pkg.sv
// Shared definitions for the clock-recovery / bit-sampling blocks.
// Holds the FSM encoding, the default period width and the period validity bounds.
package bit_sampler_pkg;

   localparam int CLK_LEN_DEF = 32;
   // Periods below this are too short to place a mid-bit strobe; all-ones means "no lock".
   localparam int FREQ_MIN    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HUNT = 2'd1,
      ST_DATA = 2'd2
   } state_t;

endpackage

// File: rtl/bit_sampler_if.sv
// Byte output handshake between the sampler (master) and its consumer (slave).
interface bit_sampler_if;

   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_data, output byte_valid, input byte_ready);
   modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/mid_bit_strobe.sv
// Synchronizes the serial line and fires one strobe a quarter period after each
// recovered-clock rise, capturing the synchronized line value at that moment.
module mid_bit_strobe
   import bit_sampler_pkg::*;
#(
   parameter int CLK_LEN = CLK_LEN_DEF
) (
   input  logic               clk_300M,
   input  logic               rst,
   input  logic               i_signal,
   input  logic               i_clk_rec,
   input  logic [CLK_LEN-1:0] i_clk_freq,
   output logic               o_sample_stb,
   output logic               o_sample_bit
);

   logic               r_sig_meta;
   logic               r_sig_s;
   logic               r_clk_rec_d;
   logic [CLK_LEN-1:0] r_dly_cnt;
   logic               r_stb;
   logic               r_bit;
   logic               w_rise;

   assign w_rise       = i_clk_rec & ~r_clk_rec_d;
   assign o_sample_stb = r_stb;
   assign o_sample_bit = r_bit;

   // A new rise always restarts the countdown, so an interrupted bit never strobes.
   always_ff @(posedge clk_300M) begin
      if (rst) begin
         r_sig_meta  <= 1'b0;
         r_sig_s     <= 1'b0;
         r_clk_rec_d <= 1'b0;
         r_dly_cnt   <= '0;
         r_stb       <= 1'b0;
         r_bit       <= 1'b0;
      end else begin
         r_sig_meta  <= i_signal;
         r_sig_s     <= r_sig_meta;
         r_clk_rec_d <= i_clk_rec;
         r_stb       <= 1'b0;
         if (w_rise) begin
            r_dly_cnt <= i_clk_freq >> 2;
         end else if (r_dly_cnt != '0) begin
            r_dly_cnt <= r_dly_cnt - CLK_LEN'(1);
            if (r_dly_cnt == CLK_LEN'(1)) begin
               r_stb <= 1'b1;
               r_bit <= r_sig_s;
            end
         end
      end
   end

endmodule

// File: rtl/bit_sampler.sv
// Frame-sync hunter and byte assembler on top of the mid-bit strobe, with a
// one-entry output holding register and a sticky overflow flag.
module bit_sampler
   import bit_sampler_pkg::*;
#(
   parameter int         CLK_LEN     = CLK_LEN_DEF,
   parameter logic [7:0] SYNC_WORD   = 8'hA5,
   parameter int         FRAME_BYTES = 4
) (
   input  logic               clk_300M,
   input  logic               rst,
   input  logic               signal,
   input  logic               clk_rec,
   input  logic [CLK_LEN-1:0] clk_freq,
   bit_sampler_if.master      byte_if,
   output logic               frame_start,
   output logic               locked,
   output logic               overflow
);

   localparam int BC_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_nxt;
   logic [7:0]      w_shift_in;
   logic [2:0]      r_bit_cnt;
   logic [2:0]      w_bit_cnt_nxt;
   logic [BC_W-1:0] r_byte_cnt;
   logic [BC_W-1:0] w_byte_cnt_nxt;
   logic            w_fs_nxt;
   logic            w_byte_done;
   logic            w_freq_valid;
   logic            w_stb;
   logic            w_bit;
   logic            r_frame_start;
   logic [7:0]      r_byte_data;
   logic            r_byte_valid;
   logic            r_overflow;

   mid_bit_strobe #(
      .CLK_LEN (CLK_LEN)
   ) u_strobe (
      .clk_300M     (clk_300M),
      .rst          (rst),
      .i_signal     (signal),
      .i_clk_rec    (clk_rec),
      .i_clk_freq   (clk_freq),
      .o_sample_stb (w_stb),
      .o_sample_bit (w_bit)
   );

   assign w_freq_valid       = (clk_freq >= CLK_LEN'(FREQ_MIN)) && (clk_freq != '1);
   assign locked             = (r_state == ST_HUNT) || (r_state == ST_DATA);
   assign frame_start        = r_frame_start;
   assign overflow           = r_overflow;
   assign byte_if.byte_data  = r_byte_data;
   assign byte_if.byte_valid = r_byte_valid;

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_byte_cnt_nxt = r_byte_cnt;
      w_fs_nxt       = 1'b0;
      w_byte_done    = 1'b0;
      w_shift_in     = {r_shift[6:0], w_bit};
      if (!w_freq_valid) begin
         w_state_nxt    = ST_IDLE;
         w_shift_nxt    = '0;
         w_bit_cnt_nxt  = '0;
         w_byte_cnt_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_HUNT;
            ST_HUNT: begin
               if (w_stb) begin
                  w_shift_nxt = w_shift_in;
                  if (w_shift_in == SYNC_WORD) begin
                     w_state_nxt    = ST_DATA;
                     w_fs_nxt       = 1'b1;
                     w_bit_cnt_nxt  = '0;
                     w_byte_cnt_nxt = '0;
                  end
               end
            end
            ST_DATA: begin
               if (w_stb) begin
                  w_shift_nxt   = w_shift_in;
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     w_byte_done = 1'b1;
                     // Clearing the shifter forces a full fresh sync word before the next frame.
                     if (r_byte_cnt == BC_W'(FRAME_BYTES - 1)) begin
                        w_state_nxt    = ST_HUNT;
                        w_shift_nxt    = '0;
                        w_byte_cnt_nxt = '0;
                     end else begin
                        w_byte_cnt_nxt = r_byte_cnt + BC_W'(1);
                     end
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_300M) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_byte_cnt    <= '0;
         r_frame_start <= 1'b0;
         r_byte_data   <= '0;
         r_byte_valid  <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_shift       <= w_shift_nxt;
         r_bit_cnt     <= w_bit_cnt_nxt;
         r_byte_cnt    <= w_byte_cnt_nxt;
         r_frame_start <= w_fs_nxt;
         // A completing byte may replace the held one only if that one leaves this cycle.
         if (w_byte_done && (!r_byte_valid || byte_if.byte_ready)) begin
            r_byte_data  <= w_shift_in;
            r_byte_valid <= 1'b1;
         end else if (w_byte_done) begin
            r_overflow   <= 1'b1;
         end else if (r_byte_valid && byte_if.byte_ready) begin
            r_byte_valid <= 1'b0;
         end
      end
   end

endmodule
